// File: rtl/regfile_sb_if.sv
// Decode/writeback bus for regfile_sb. It carries the read ports, the writeback
// port, the scoreboard claim port and the clear/ready handshake.
interface regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int LANES = DATA_W / 8;

    logic              clr_req;
    logic              ready;
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              ra_busy;
    logic              rb_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_data;
    logic              claim_en;
    logic [ADDR_W-1:0] claim_addr;
    logic              claim_ok;

    modport master (
        output clr_req, ra_addr, rb_addr, wr_en, wr_addr, wr_be, wr_data,
               claim_en, claim_addr,
        input  ready, ra_data, rb_data, ra_busy, rb_busy, claim_ok
    );

    modport slave (
        input  clr_req, ra_addr, rb_addr, wr_en, wr_addr, wr_be, wr_data,
               claim_en, claim_addr,
        output ready, ra_data, rb_data, ra_busy, rb_busy, claim_ok
    );
endinterface

// File: rtl/regfile_sb.sv
// Dual-read, byte-enabled register file with write-to-read forwarding, a
// self-clearing sequencer and a per-register busy scoreboard.
//
// state | meaning
// CLEAR | zeroing reg[clrCnt] each cycle; all ports quiet, ready=0
// RUN   | normal read/write/claim operation, ready=1
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] clrCnt;
    logic [DATA_W-1:0] regArray [NREGS];
    logic [NREGS-1:0]  busy;
    logic              running;
    logic              clrDone;
    logic              claimOk;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;

    assign running = (state == RUN);
    assign clrDone = (clrCnt == ADDR_W'(NREGS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            CLEAR:   if (clrDone) stateNext = RUN;
            RUN:     if (bus.clr_req) stateNext = CLEAR;
            default: stateNext = CLEAR;
        endcase
    end

    // Claim beats release on the same address, so the claim is applied last.
    always_ff @(posedge clk) begin
        if (rst) begin
            clrCnt <= '0;
            busy   <= '0;
        end else if (!running) begin
            clrCnt <= clrCnt + 1'b1;
        end else if (bus.clr_req) begin
            clrCnt <= '0;
            busy   <= '0;
        end else begin
            if (bus.wr_en) busy[bus.wr_addr]    <= 1'b0;
            if (claimOk)   busy[bus.claim_addr] <= 1'b1;
        end
    end

    // The array has no reset of its own; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!running) begin
                regArray[clrCnt] <= '0;
            end else if (bus.wr_en) begin
                for (int i = 0; i < LANES; i++)
                    if (bus.wr_be[i]) regArray[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        dataA = regArray[bus.ra_addr];
        dataB = regArray[bus.rb_addr];
        for (int i = 0; i < LANES; i++) begin
            if (bus.wr_en && bus.wr_be[i] && bus.wr_addr == bus.ra_addr)
                dataA[8*i +: 8] = bus.wr_data[8*i +: 8];
            if (bus.wr_en && bus.wr_be[i] && bus.wr_addr == bus.rb_addr)
                dataB[8*i +: 8] = bus.wr_data[8*i +: 8];
        end
    end

    assign claimOk = running && bus.claim_en &&
                     (!busy[bus.claim_addr] || (bus.wr_en && bus.wr_addr == bus.claim_addr));

    assign bus.ready    = running;
    assign bus.ra_data  = running ? dataA : '0;
    assign bus.rb_data  = running ? dataB : '0;
    assign bus.ra_busy  = running && busy[bus.ra_addr];
    assign bus.rb_busy  = running && busy[bus.rb_addr];
    assign bus.claim_ok = claimOk;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the 8×16 register file: a single-write, dual-read register file with generic width and depth, per-byte write enables, and same-cycle write-to-read forwarding. It adds a self-clearing sequencer that zeroes every register after reset or on request. It also adds a per-register busy scoreboard, so the decode stage can claim destinations and stall on pending writebacks. It sits between decode (read, claim) and writeback (write, release) in the CPU datapath.

## Interface
Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W.
- LANES, DATA_W/8, derived byte-lane count; not overridable.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  request a full re-clear; honoured only while ready=1.
- ready  out  1  1 = RUN state, file usable.
- ra_addr  in  ADDR_W  read port A address.
- rb_addr  in  ADDR_W  read port B address.
- ra_data  out  DATA_W  port A data, combinational.
- rb_data  out  DATA_W  port B data, combinational.
- ra_busy  out  1  scoreboard bit of ra_addr.
- rb_busy  out  1  scoreboard bit of rb_addr.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_be  in  LANES  byte enables; bit i covers data[8i+7:8i].
- wr_data  in  DATA_W  writeback data.
- claim_en  in  1  decode requests to mark a destination busy.
- claim_addr  in  ADDR_W  destination to claim.
- claim_ok  out  1  claim accepted this cycle, combinational.

## Operation
- FSM states: CLEAR, RUN. rst → CLEAR with clear counter cnt=0 and all busy bits = 0.
- CLEAR:
  - Each cycle, reg[cnt] <= 0 and cnt increments.
  - When cnt == NREGS-1, move to RUN.
  - wr_en, claim_en and clr_req are ignored.
  - ready=0, ra_data=rb_data=0, ra_busy=rb_busy=0, claim_ok=0.
- RUN:
  - Write: if wr_en, reg[wr_addr] lane i <= wr_data lane i for each wr_be[i]=1; other lanes hold. wr_en with wr_be=0 writes nothing.
  - Release: if wr_en (any wr_be), busy[wr_addr] <= 0.
  - Read: ra_data = reg[ra_addr], with forwarding. If wr_en && wr_addr==ra_addr, each lane with wr_be[i]=1 is taken from wr_data; the other lanes come from the array. Port B uses the same rule. Both ports may read the same address.
  - Claim: claim_ok = claim_en && (!busy[claim_addr] || (wr_en && wr_addr==claim_addr)). If claim_ok, busy[claim_addr] <= 1; when release and claim hit the same address, the claim wins.
  - ra_busy/rb_busy show the registered busy bits. They do not reflect same-cycle release or claim.
  - clr_req=1 → CLEAR next cycle (cnt=0, busy all 0). A write in the same cycle as clr_req is performed, then overwritten by the clear.
- No hardwired-zero register; all NREGS entries are writable.

## Timing
- Read path and claim_ok: combinational, zero latency. Writes, busy updates and FSM changes: one edge.
- After rst deasserts in cycle 0, registers 0..NREGS-1 are zeroed in cycles 0..NREGS-1. ready=1 from cycle NREGS; with the defaults, 8 cycles of ready=0.
- rst asserted mid-CLEAR or mid-RUN restarts CLEAR at cnt=0 at the next edge. Array contents are not otherwise reset.
- A write in cycle n is visible through the array from cycle n+1, and through forwarding in cycle n.
- Reset values: ready=0, claim_ok=0, ra_busy=rb_busy=0, ra_data=rb_data=0.

## Test plan
- Reset then idle: ready low for exactly NREGS cycles. Afterwards, reading every address on both ports returns 0x0000 and busy=0.
- Byte enables: reg5=0x1234, then write 0xABCD with wr_be=2'b01 → reg5=0x12CD. wr_be=2'b10 with 0xEF00 → 0xEFCD. wr_be=0 → unchanged.
- Forwarding: reg2=0x1111. In the same cycle, write 0x2222 be=2'b10 to addr 2 with ra_addr=rb_addr=2 → both ports show 0x2211; the next cycle shows 0x2211 from the array.
- Scoreboard:
  - claim 3 → claim_ok=1 and ra_busy(3)=1 next cycle.
  - A second claim of 3 → claim_ok=0.
  - Writeback to 3 with a same-cycle claim of 3 → claim_ok=1 and busy stays 1.
  - Writeback alone → busy 0.
- clr_req mid-run: registers hold nonzero values and busy bits are set. Pulse clr_req together with a write → ready=0 for NREGS cycles, then all registers 0, all busy 0; writes and claims during CLEAR have no effect.
- rst at cycle 3 of CLEAR → counter restarts and ready rises exactly NREGS cycles after rst deasserts.
